// File: rtl/proc_control_unit.sv
// Control-step FSM for the 16-bit simple processor: captures an instruction into IR and sequences
// mux selects and register enables through T0..T3. Optional mvnz opcode enabled by `define CU_MVNZ_EN.
module proc_control_unit #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] Din,
  input  logic              Gnz,
  output logic              IRin,
  output logic [7:0]        Rin,
  output logic [7:0]        selectR,
  output logic              selectG,
  output logic              selectDin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done,
  output logic [1:0]        Tstep
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  tstep_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;

  logic [2:0] opc, rx, ry;
  logic       is_arith;

  assign opc      = ir_q[8:6];
  assign rx       = ir_q[5:3];
  assign ry       = ir_q[2:0];
  assign is_arith = (opc == OP_ADD) || (opc == OP_SUB);
  assign Tstep    = state_q;

`ifdef CU_MVNZ_EN
  logic unused_din;
  assign unused_din = ^Din[DATA_W-1:IR_W];
`else
  logic unused_din;
  assign unused_din = ^{Din[DATA_W-1:IR_W], Gnz, OP_MVNZ};
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Run is a level start request: it is accepted only in T0 (IRin is the acknowledge) and is
  // ignored in every other step, so holding it high chains instructions back to back.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    IRin      = 1'b0;
    Rin       = 8'd0;
    selectR   = 8'd0;
    selectG   = 1'b0;
    selectDin = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    AddSub    = 1'b0;
    Done      = 1'b0;

    case (state_q)
      T0: begin
        if (Run) begin
          IRin    = 1'b1;
          ir_d    = Din[IR_W-1:0];
          state_d = T1;
        end
      end
      T1: begin
        state_d = T0;
        case (opc)
          OP_MV: begin
            selectR = {5'd0, ry};
            Rin     = 8'd1 << rx;
            Done    = 1'b1;
          end
          OP_MVI: begin
            selectDin = 1'b1;
            Rin       = 8'd1 << rx;
            Done      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            selectR = {5'd0, rx};
            Ain     = 1'b1;
            state_d = T2;
          end
`ifdef CU_MVNZ_EN
          OP_MVNZ: begin
            selectR = {5'd0, ry};
            Rin     = Gnz ? (8'd1 << rx) : 8'd0;
            Done    = 1'b1;
          end
`endif
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        // A non-arithmetic opcode here is an illegal state: outputs stay 0 and we return to T0.
        state_d = T0;
        if (is_arith) begin
          selectR = {5'd0, ry};
          Gin     = 1'b1;
          AddSub  = (opc == OP_SUB);
          state_d = T3;
        end
      end
      T3: begin
        state_d = T0;
        if (is_arith) begin
          selectG = 1'b1;
          Rin     = 8'd1 << rx;
          Done    = 1'b1;
        end
      end
      default: state_d = T0;
    endcase

    if (Reset) begin
      IRin      = 1'b0;
      Rin       = 8'd0;
      selectR   = 8'd0;
      selectG   = 1'b0;
      selectDin = 1'b0;
      Ain       = 1'b0;
      Gin       = 1'b0;
      AddSub    = 1'b0;
      Done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed testbench for proc_control_unit: hand-computed per-step output vectors.
module tb_proc_control_unit;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [15:0] Din;
  logic        Gnz;
  logic        IRin;
  logic [7:0]  Rin;
  logic [7:0]  selectR;
  logic        selectG;
  logic        selectDin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;
  logic [1:0]  Tstep;

  int n_checks = 0;
  int n_errors = 0;

  proc_control_unit dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Din(Din), .Gnz(Gnz),
    .IRin(IRin), .Rin(Rin), .selectR(selectR), .selectG(selectG),
    .selectDin(selectDin), .Ain(Ain), .Gin(Gin), .AddSub(AddSub),
    .Done(Done), .Tstep(Tstep)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed order: {IRin, Rin, selectR, selectG, selectDin, Ain, Gin, AddSub, Done, Tstep}
  task automatic expect_outs(input string tag, input logic irin, input logic [7:0] rin,
                             input logic [7:0] selr, input logic selg, input logic seldin,
                             input logic ain, input logic gin, input logic addsub,
                             input logic done, input logic [1:0] ts);
    check(tag,
          {7'd0, IRin, Rin, selectR, selectG, selectDin, Ain, Gin, AddSub, Done, Tstep},
          {7'd0, irin, rin, selr, selg, seldin, ain, gin, addsub, done, ts});
  endtask

  task automatic next_cycle;
    @(negedge Clock);
  endtask

  logic [7:0] mvnz_rin_g1;
  logic [7:0] mvnz_selr;

  initial begin
`ifdef CU_MVNZ_EN
    mvnz_rin_g1 = 8'h01;
    mvnz_selr   = 8'd5;
`else
    mvnz_rin_g1 = 8'h00;
    mvnz_selr   = 8'd0;
`endif

    // Reset held with Run high: everything quiet
    Reset = 1'b1; Run = 1'b1; Gnz = 1'b0; Din = 16'h0000 | 16'(9'b001_010_000);
    next_cycle(); next_cycle(); #1;
    expect_outs("rst_run_high", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);

    // mvi R2: IRin in the same cycle reset drops
    Reset = 1'b0; #1;
    expect_outs("mvi_t0_irin", 1, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    next_cycle(); Run = 1'b0; #1;
    expect_outs("mvi_t1", 0, 8'h04, 8'd0, 0, 1, 0, 0, 0, 1, 2'd1);
    next_cycle(); #1;
    expect_outs("mvi_back_t0", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);

    // add R1,R3
    Din = 16'(9'b010_001_011); Run = 1'b1; #1;
    expect_outs("add_t0", 1, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    next_cycle(); Run = 1'b0; #1;
    expect_outs("add_t1", 0, 8'h00, 8'd1, 0, 0, 1, 0, 0, 0, 2'd1);
    next_cycle(); #1;
    expect_outs("add_t2", 0, 8'h00, 8'd3, 0, 0, 0, 1, 0, 0, 2'd2);
    next_cycle(); #1;
    expect_outs("add_t3", 0, 8'h02, 8'd0, 1, 0, 0, 0, 0, 1, 2'd3);
    next_cycle(); #1;
    expect_outs("add_back_t0", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);

    // sub R7,R7 with Run held high throughout, then chained mv R0,R5
    Din = 16'(9'b011_111_111); Run = 1'b1; #1;
    expect_outs("sub_t0", 1, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    next_cycle(); Din = 16'(9'b000_000_101); #1;
    expect_outs("sub_t1_run_ignored", 0, 8'h00, 8'd7, 0, 0, 1, 0, 0, 0, 2'd1);
    next_cycle(); #1;
    expect_outs("sub_t2", 0, 8'h00, 8'd7, 0, 0, 0, 1, 1, 0, 2'd2);
    next_cycle(); #1;
    expect_outs("sub_t3", 0, 8'h80, 8'd0, 1, 0, 0, 0, 0, 1, 2'd3);
    next_cycle(); #1;
    expect_outs("chain_t0_irin", 1, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    next_cycle(); Run = 1'b0; #1;
    expect_outs("mv_t1", 0, 8'h01, 8'd5, 0, 0, 0, 0, 0, 1, 2'd1);
    next_cycle(); #1;
    expect_outs("mv_back_t0", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);

    // add R3,R3 interrupted by reset in T2
    Din = 16'(9'b010_011_011); Run = 1'b1;
    next_cycle(); Run = 1'b0;
    next_cycle(); #1;
    expect_outs("abort_t2", 0, 8'h00, 8'd3, 0, 0, 0, 1, 0, 0, 2'd2);
    Reset = 1'b1; #1;
    expect_outs("abort_rst", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    check("abort_ir_cleared", 32'(dut.ir_q), 32'd0);
    next_cycle(); #1;
    expect_outs("abort_rst_held", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    Reset = 1'b0;
    next_cycle(); #1;
    expect_outs("abort_idle", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);

    // NOP opcode 101: only Done in T1
    Din = 16'(9'b101_011_010); Run = 1'b1; #1;
    expect_outs("nop_t0", 1, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    next_cycle(); Run = 1'b0; #1;
    expect_outs("nop_t1", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 1, 2'd1);
    next_cycle(); #1;
    expect_outs("nop_back_t0", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);

    // opcode 100 with Gnz=0 then Gnz=1
    Din = 16'(9'b100_000_101); Run = 1'b1; Gnz = 1'b0;
    next_cycle(); Run = 1'b0; #1;
    expect_outs("mvnz_g0", 0, 8'h00, mvnz_selr, 0, 0, 0, 0, 0, 1, 2'd1);
    next_cycle(); Run = 1'b1; Gnz = 1'b1;
    next_cycle(); Run = 1'b0; #1;
    expect_outs("mvnz_g1", 0, mvnz_rin_g1, mvnz_selr, 0, 0, 0, 0, 0, 1, 2'd1);
    next_cycle(); #1;
    expect_outs("mvnz_back_t0", 0, 8'h00, 8'd0, 0, 0, 0, 0, 0, 0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
